// File: rtl/msrh_pkg.sv
// rtl/msrh_pkg.sv - shared types and defaults for the L1D miss-status holding register file
package msrh_pkg;

  // Default number of MSHR entries.
  localparam int LRQ_ENTRY_SIZE = 4;

  // Default line-address width (56-bit physical address, 64-byte lines).
  localparam int LRQ_LA_W = 50;

  // Life cycle of one outstanding line miss.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } lrq_state_t;

  // Architectural view of one entry: state plus the line address it tracks.
  typedef struct packed {
    lrq_state_t            state;
    logic [LRQ_LA_W-1:0]   paddr;
  } mshr_entry_t;

endpackage

// File: rtl/msrh_mshr_entry.sv
// rtl/msrh_mshr_entry.sv - one MSHR entry: state machine plus captured line address
module msrh_mshr_entry
  import msrh_pkg::*;
#(
  parameter int LA_W = LRQ_LA_W
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_load,
  input  logic [LA_W-1:0] i_load_paddr,
  input  logic            i_sent,
  input  logic            i_resp,
  input  logic            i_release,
  output lrq_state_t      o_state,
  output logic [LA_W-1:0] o_paddr
);

  lrq_state_t      state_q;
  logic [LA_W-1:0] paddr_q;

  // Entry FSM; the line address is captured only on allocation and held until reuse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      paddr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_load) begin
            state_q <= SEND;
            paddr_q <= i_load_paddr;
          end
        end
        SEND:    if (i_sent)    state_q <= WAIT;
        WAIT:    if (i_resp)    state_q <= FILL;
        FILL:    if (i_release) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_state = state_q;
  assign o_paddr = paddr_q;

endmodule

// File: rtl/msrh_l1d_mshr.sv
// rtl/msrh_l1d_mshr.sv - multi-port L1D MSHR file with merge, round-robin issue and fill broadcast
module msrh_l1d_mshr
  import msrh_pkg::*;
#(
  parameter  int N_PORTS    = 2,
  parameter  int ENTRY_SIZE = LRQ_ENTRY_SIZE,
  parameter  int PADDR_W    = 56,
  parameter  int LINE_B     = 64,
  parameter  int DATA_W     = 512,
  localparam int IDX_W      = $clog2(ENTRY_SIZE),
  localparam int OFF_W      = $clog2(LINE_B),
  localparam int LA_W       = PADDR_W - OFF_W
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [N_PORTS-1:0]         i_req_valid,
  input  logic [N_PORTS*PADDR_W-1:0] i_req_paddr,
  output logic [N_PORTS-1:0]         o_req_full,
  output logic [N_PORTS-1:0]         o_req_merged,
  output logic [N_PORTS*IDX_W-1:0]   o_req_idx,
  output logic                       o_ext_req_valid,
  input  logic                       i_ext_req_ready,
  output logic [LA_W-1:0]            o_ext_req_paddr,
  output logic [IDX_W-1:0]           o_ext_req_tag,
  input  logic                       i_ext_resp_valid,
  input  logic [IDX_W-1:0]           i_ext_resp_tag,
  input  logic [DATA_W-1:0]          i_ext_resp_data,
  output logic                       o_fill_valid,
  output logic [IDX_W-1:0]           o_fill_idx,
  output logic [LA_W-1:0]            o_fill_paddr,
  output logic [DATA_W-1:0]          o_fill_data,
  output logic [ENTRY_SIZE-1:0]      o_entry_busy
);

  // Per-entry view and control
  lrq_state_t             ent_state      [ENTRY_SIZE];
  logic [LA_W-1:0]        ent_paddr      [ENTRY_SIZE];
  logic [LA_W-1:0]        ent_load_paddr [ENTRY_SIZE];
  logic [ENTRY_SIZE-1:0]  ent_load;
  logic [ENTRY_SIZE-1:0]  ent_sent;
  logic [ENTRY_SIZE-1:0]  ent_resp;
  logic [ENTRY_SIZE-1:0]  ent_release;

  // Request-side decode
  logic [LA_W-1:0]        req_la    [N_PORTS];
  logic [IDX_W-1:0]       alloc_idx [N_PORTS];
  logic [N_PORTS-1:0]     alloc_en;
  logic [ENTRY_SIZE-1:0]  taken;
  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  logic                   found;
  logic [IDX_W-1:0]       free_idx;
  logic                   unused_req_off;

  // Issue side
  logic [IDX_W-1:0]       ptr_q;
  logic                   lock_q;
  logic [IDX_W-1:0]       lock_tag_q;
  logic                   rr_found;
  logic [IDX_W-1:0]       rr_sel;
  logic [IDX_W-1:0]       rr_cand;
  logic                   iss_valid;
  logic [IDX_W-1:0]       iss_sel;
  logic                   iss_hs;

  // Response / fill side
  logic                   resp_hit;
  logic                   resp_bad;
  logic                   fill_valid_q;
  logic [IDX_W-1:0]       fill_idx_q;
  logic [LA_W-1:0]        fill_paddr_q;
  logic [DATA_W-1:0]      fill_data_q;

  for (genvar e = 0; e < ENTRY_SIZE; e++) begin : g_ent
    msrh_mshr_entry #(.LA_W(LA_W)) u_entry (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_load       (ent_load[e]),
      .i_load_paddr (ent_load_paddr[e]),
      .i_sent       (ent_sent[e]),
      .i_resp       (ent_resp[e]),
      .i_release    (ent_release[e]),
      .o_state      (ent_state[e]),
      .o_paddr      (ent_paddr[e])
    );
  end

  // Strip the in-line offset; only the line address takes part in matching.
  always_comb begin
    unused_req_off = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      req_la[p]      = i_req_paddr[p*PADDR_W + OFF_W +: LA_W];
      unused_req_off = unused_req_off ^ (^i_req_paddr[p*PADDR_W +: OFF_W]);
    end
  end

  // Merge/allocate in port order: existing SEND/WAIT line, then a lower port's new entry, then lowest free IDLE entry.
  always_comb begin
    taken        = '0;
    ent_load     = '0;
    alloc_en     = '0;
    o_req_full   = '0;
    o_req_merged = '0;
    o_req_idx    = '0;
    hit          = 1'b0;
    hit_idx      = '0;
    found        = 1'b0;
    free_idx     = '0;
    for (int e = 0; e < ENTRY_SIZE; e++) ent_load_paddr[e] = '0;
    for (int q = 0; q < N_PORTS; q++) alloc_idx[q] = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      hit      = 1'b0;
      hit_idx  = '0;
      found    = 1'b0;
      free_idx = '0;
      for (int e = 0; e < ENTRY_SIZE; e++) begin
        if (!hit && (ent_state[e] == SEND || ent_state[e] == WAIT) && ent_paddr[e] == req_la[p]) begin
          hit     = 1'b1;
          hit_idx = IDX_W'(e);
        end
      end
      for (int q = 0; q < N_PORTS; q++) begin
        if (!hit && q < p && alloc_en[q] && req_la[q] == req_la[p]) begin
          hit     = 1'b1;
          hit_idx = alloc_idx[q];
        end
      end
      for (int e = 0; e < ENTRY_SIZE; e++) begin
        if (!found && ent_state[e] == IDLE && !taken[e]) begin
          found    = 1'b1;
          free_idx = IDX_W'(e);
        end
      end
      if (i_req_valid[p]) begin
        if (hit) begin
          o_req_merged[p]               = 1'b1;
          o_req_idx[p*IDX_W +: IDX_W]   = hit_idx;
        end else if (found) begin
          alloc_en[p]                   = 1'b1;
          alloc_idx[p]                  = free_idx;
          taken[free_idx]               = 1'b1;
          ent_load[free_idx]            = 1'b1;
          ent_load_paddr[free_idx]      = req_la[p];
          o_req_idx[p*IDX_W +: IDX_W]   = free_idx;
        end else begin
          o_req_full[p]                 = 1'b1;
        end
      end
    end
  end

  // Round-robin search for the first SEND entry at or after the pointer.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_cand  = '0;
    for (int k = 0; k < ENTRY_SIZE; k++) begin
      rr_cand = IDX_W'((int'(ptr_q) + k) % ENTRY_SIZE);
      if (!rr_found && ent_state[rr_cand] == SEND) begin
        rr_found = 1'b1;
        rr_sel   = rr_cand;
      end
    end
  end

  // A stalled request stays locked on its entry so a newly allocated lower index cannot displace it.
  assign iss_valid = lock_q | rr_found;
  assign iss_sel   = lock_q ? lock_tag_q : rr_sel;
  assign iss_hs    = iss_valid & i_ext_req_ready;

  // Issue pointer advances past the granted entry; lock holds a stalled grant.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_tag_q <= '0;
    end else begin
      lock_q     <= iss_valid & ~i_ext_req_ready;
      lock_tag_q <= iss_sel;
      if (iss_hs) begin
        if (iss_sel == IDX_W'(ENTRY_SIZE - 1)) ptr_q <= '0;
        else                                   ptr_q <= iss_sel + 1'b1;
      end
    end
  end

  assign resp_hit = i_ext_resp_valid && (ent_state[i_ext_resp_tag] == WAIT);
  assign resp_bad = i_ext_resp_valid &&
                    (ent_state[i_ext_resp_tag] == SEND || ent_state[i_ext_resp_tag] == FILL);

  // Per-entry strobes: issue grant, response match, and automatic release after the fill cycle.
  always_comb begin
    for (int e = 0; e < ENTRY_SIZE; e++) begin
      ent_sent[e]     = iss_hs && (iss_sel == IDX_W'(e));
      ent_resp[e]     = resp_hit && (i_ext_resp_tag == IDX_W'(e));
      ent_release[e]  = (ent_state[e] == FILL);
      o_entry_busy[e] = (ent_state[e] != IDLE);
    end
  end

  // Shared fill register: one broadcast per accepted response.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fill_valid_q <= 1'b0;
      fill_idx_q   <= '0;
      fill_paddr_q <= '0;
      fill_data_q  <= '0;
    end else begin
      fill_valid_q <= resp_hit;
      if (resp_hit) begin
        fill_idx_q   <= i_ext_resp_tag;
        fill_paddr_q <= ent_paddr[i_ext_resp_tag];
        fill_data_q  <= i_ext_resp_data;
      end
    end
  end

  assign o_ext_req_valid = iss_valid;
  assign o_ext_req_paddr = iss_valid ? ent_paddr[iss_sel] : '0;
  assign o_ext_req_tag   = iss_valid ? iss_sel : '0;
  assign o_fill_valid    = fill_valid_q;
  assign o_fill_idx      = fill_idx_q;
  assign o_fill_paddr    = fill_paddr_q;
  assign o_fill_data     = fill_data_q;

  // A response to an entry that is still SEND or already FILL is a protocol error; IDLE hits are stale post-reset traffic.
  a_resp_state : assert property (@(posedge i_clk) disable iff (i_reset) !resp_bad)
    else $error("msrh_l1d_mshr: response to entry not in WAIT");

endmodule

// File: tb/tb_msrh_l1d_mshr.sv
// tb/tb_msrh_l1d_mshr.sv - directed self-checking bench for msrh_l1d_mshr
module tb_msrh_l1d_mshr;

  localparam int N_PORTS = 2;
  localparam int ENTRY_SIZE = 4;
  localparam int PADDR_W = 56;
  localparam int LINE_B = 64;
  localparam int DATA_W = 512;
  localparam int IDX_W = 2;
  localparam int LA_W = 50;

  logic                       clk;
  logic                       reset;
  logic [N_PORTS-1:0]         req_valid;
  logic [N_PORTS*PADDR_W-1:0] req_paddr;
  logic [N_PORTS-1:0]         req_full;
  logic [N_PORTS-1:0]         req_merged;
  logic [N_PORTS*IDX_W-1:0]   req_idx;
  logic                       ext_req_valid;
  logic                       ext_req_ready;
  logic [LA_W-1:0]            ext_req_paddr;
  logic [IDX_W-1:0]           ext_req_tag;
  logic                       resp_valid;
  logic [IDX_W-1:0]           resp_tag;
  logic [DATA_W-1:0]          resp_data;
  logic                       fill_valid;
  logic [IDX_W-1:0]           fill_idx;
  logic [LA_W-1:0]            fill_paddr;
  logic [DATA_W-1:0]          fill_data;
  logic [ENTRY_SIZE-1:0]      entry_busy;

  int checks = 0;
  int errors = 0;

  msrh_l1d_mshr #(
    .N_PORTS(N_PORTS), .ENTRY_SIZE(ENTRY_SIZE), .PADDR_W(PADDR_W), .LINE_B(LINE_B), .DATA_W(DATA_W)
  ) dut (
    .i_clk(clk), .i_reset(reset),
    .i_req_valid(req_valid), .i_req_paddr(req_paddr),
    .o_req_full(req_full), .o_req_merged(req_merged), .o_req_idx(req_idx),
    .o_ext_req_valid(ext_req_valid), .i_ext_req_ready(ext_req_ready),
    .o_ext_req_paddr(ext_req_paddr), .o_ext_req_tag(ext_req_tag),
    .i_ext_resp_valid(resp_valid), .i_ext_resp_tag(resp_tag), .i_ext_resp_data(resp_data),
    .o_fill_valid(fill_valid), .o_fill_idx(fill_idx), .o_fill_paddr(fill_paddr), .o_fill_data(fill_data),
    .o_entry_busy(entry_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_inputs;
    req_valid = '0; req_paddr = '0; ext_req_ready = 1'b0;
    resp_valid = 1'b0; resp_tag = '0; resp_data = '0;
  endtask

  task automatic set_req(input int p, input logic [PADDR_W-1:0] a);
    req_valid[p] = 1'b1;
    req_paddr[p*PADDR_W +: PADDR_W] = a;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    checks++; if (entry_busy !== 4'b0000) begin errors++; $display("FAIL reset_busy: got %b exp 0000", entry_busy); end
    checks++; if (ext_req_valid !== 1'b0) begin errors++; $display("FAIL reset_ext_valid: got %b exp 0", ext_req_valid); end
    checks++; if (ext_req_paddr !== 50'h0) begin errors++; $display("FAIL reset_ext_paddr: got %h exp 0", ext_req_paddr); end
    checks++; if (fill_valid !== 1'b0) begin errors++; $display("FAIL reset_fill_valid: got %b exp 0", fill_valid); end
    checks++; if (fill_data !== 512'h0) begin errors++; $display("FAIL reset_fill_data: got %h exp 0", fill_data); end
    checks++; if (req_full !== 2'b00) begin errors++; $display("FAIL reset_full: got %b exp 00", req_full); end
    reset = 1'b0;
  endtask

  task automatic test_single_miss;
    logic [DATA_W-1:0] d;
    d = {16{32'hC0DE_0001}};
    do_reset();
    set_req(0, 56'h1000);
    settle();
    checks++; if ({req_full[0], req_merged[0], req_idx[1:0]} !== 4'b0000) begin errors++; $display("FAIL t1_req: got full/merged/idx %b exp 0000", {req_full[0], req_merged[0], req_idx[1:0]}); end
    tick();
    req_valid = '0;
    settle();
    checks++; if ({ext_req_valid, ext_req_tag} !== 3'b100) begin errors++; $display("FAIL t1_ext_req: got valid/tag %b exp 100", {ext_req_valid, ext_req_tag}); end
    checks++; if (ext_req_paddr !== 50'h40) begin errors++; $display("FAIL t1_ext_paddr: got %h exp 40", ext_req_paddr); end
    ext_req_ready = 1'b1;
    tick();
    ext_req_ready = 1'b0;
    settle();
    checks++; if (ext_req_valid !== 1'b0) begin errors++; $display("FAIL t1_ext_drop: got %b exp 0", ext_req_valid); end
    resp_valid = 1'b1; resp_tag = 2'd0; resp_data = d;
    tick();
    resp_valid = 1'b0;
    settle();
    checks++; if ({fill_valid, fill_idx} !== 3'b100) begin errors++; $display("FAIL t1_fill: got valid/idx %b exp 100", {fill_valid, fill_idx}); end
    checks++; if (fill_paddr !== 50'h40) begin errors++; $display("FAIL t1_fill_paddr: got %h exp 40", fill_paddr); end
    checks++; if (fill_data !== d) begin errors++; $display("FAIL t1_fill_data: got %h exp %h", fill_data, d); end
    tick();
    settle();
    checks++; if (fill_valid !== 1'b0) begin errors++; $display("FAIL t1_fill_one_cycle: got %b exp 0", fill_valid); end
    checks++; if (entry_busy !== 4'b0000) begin errors++; $display("FAIL t1_busy_after: got %b exp 0000", entry_busy); end
  endtask

  task automatic test_same_cycle_merge;
    do_reset();
    set_req(0, 56'h2000);
    set_req(1, 56'h2010);
    settle();
    checks++; if ({req_full, req_merged} !== 4'b0010) begin errors++; $display("FAIL t2_full_merged: got %b exp 0010", {req_full, req_merged}); end
    checks++; if (req_idx !== 4'b0000) begin errors++; $display("FAIL t2_idx: got %b exp 0000", req_idx); end
    tick();
    req_valid = '0;
    settle();
    checks++; if (entry_busy !== 4'b0001) begin errors++; $display("FAIL t2_busy: got %b exp 0001", entry_busy); end
    checks++; if ({ext_req_valid, ext_req_paddr} !== {1'b1, 50'h80}) begin errors++; $display("FAIL t2_ext: got %b/%h exp 1/80", ext_req_valid, ext_req_paddr); end
    ext_req_ready = 1'b1;
    tick();
    settle();
    checks++; if (ext_req_valid !== 1'b0) begin errors++; $display("FAIL t2_single_ext: got %b exp 0", ext_req_valid); end
    ext_req_ready = 1'b0;
  endtask

  task automatic test_full_merge;
    do_reset();
    set_req(0, 56'h10000); set_req(1, 56'h10040);
    settle();
    checks++; if (req_idx !== 4'b0100) begin errors++; $display("FAIL t3_idx_a: got %b exp 0100", req_idx); end
    tick();
    set_req(0, 56'h10080); set_req(1, 56'h100C0);
    settle();
    checks++; if ({req_full, req_merged, req_idx} !== 8'b0000_1110) begin errors++; $display("FAIL t3_idx_b: got %b exp 00001110", {req_full, req_merged, req_idx}); end
    tick();
    set_req(0, 56'h20000); set_req(1, 56'h10040);
    settle();
    checks++; if (entry_busy !== 4'b1111) begin errors++; $display("FAIL t3_busy: got %b exp 1111", entry_busy); end
    checks++; if ({req_full, req_merged} !== 4'b0110) begin errors++; $display("FAIL t3_full_merged: got %b exp 0110", {req_full, req_merged}); end
    checks++; if (req_idx[3:2] !== 2'd1) begin errors++; $display("FAIL t3_merge_idx: got %0d exp 1", req_idx[3:2]); end
    req_valid = '0;
  endtask

  task automatic test_rr_hold;
    do_reset();
    set_req(0, 56'h40000); set_req(1, 56'h40040);
    settle();
    checks++; if (req_idx !== 4'b0100) begin errors++; $display("FAIL t4_alloc_a: got %b exp 0100", req_idx); end
    tick();
    req_valid = '0;
    set_req(0, 56'h40080);
    settle();
    checks++; if (req_idx[1:0] !== 2'd2) begin errors++; $display("FAIL t4_alloc_b: got %0d exp 2", req_idx[1:0]); end
    for (int i = 0; i < 5; i++) begin
      checks++; if ({ext_req_valid, ext_req_tag, ext_req_paddr} !== {1'b1, 2'd0, 50'h1000}) begin errors++; $display("FAIL t4_hold%0d: got %b/%0d/%h exp 1/0/1000", i, ext_req_valid, ext_req_tag, ext_req_paddr); end
      tick();
      req_valid = '0;
      settle();
    end
    ext_req_ready = 1'b1;
    settle();
    checks++; if (ext_req_tag !== 2'd0) begin errors++; $display("FAIL t4_rr0: got %0d exp 0", ext_req_tag); end
    tick();
    checks++; if ({ext_req_valid, ext_req_tag, ext_req_paddr} !== {1'b1, 2'd1, 50'h1001}) begin errors++; $display("FAIL t4_rr1: got %b/%0d/%h exp 1/1/1001", ext_req_valid, ext_req_tag, ext_req_paddr); end
    tick();
    checks++; if ({ext_req_valid, ext_req_tag, ext_req_paddr} !== {1'b1, 2'd2, 50'h1002}) begin errors++; $display("FAIL t4_rr2: got %b/%0d/%h exp 1/2/1002", ext_req_valid, ext_req_tag, ext_req_paddr); end
    tick();
    ext_req_ready = 1'b0;
    settle();
    checks++; if ({ext_req_valid, entry_busy} !== 5'b0_0111) begin errors++; $display("FAIL t4_done: got %b exp 00111", {ext_req_valid, entry_busy}); end
  endtask

  task automatic test_ooo_resp;
    logic [DATA_W-1:0] d0, d1, d2;
    d0 = {16{32'hAAAA_0000}}; d1 = {16{32'hBBBB_1111}}; d2 = {16{32'hCCCC_2222}};
    resp_valid = 1'b1; resp_tag = 2'd2; resp_data = d2;
    tick();
    resp_tag = 2'd0; resp_data = d0;
    settle();
    checks++; if ({fill_valid, fill_idx, fill_paddr} !== {1'b1, 2'd2, 50'h1002}) begin errors++; $display("FAIL t5_fill2: got %b/%0d/%h exp 1/2/1002", fill_valid, fill_idx, fill_paddr); end
    checks++; if (fill_data !== d2) begin errors++; $display("FAIL t5_data2: got %h exp %h", fill_data, d2); end
    tick();
    resp_tag = 2'd1; resp_data = d1;
    settle();
    checks++; if ({fill_valid, fill_idx, fill_paddr} !== {1'b1, 2'd0, 50'h1000}) begin errors++; $display("FAIL t5_fill0: got %b/%0d/%h exp 1/0/1000", fill_valid, fill_idx, fill_paddr); end
    checks++; if (fill_data !== d0) begin errors++; $display("FAIL t5_data0: got %h exp %h", fill_data, d0); end
    tick();
    resp_tag = 2'd3; resp_data = {16{32'hDEAD_BEEF}};
    settle();
    checks++; if ({fill_valid, fill_idx, fill_paddr} !== {1'b1, 2'd1, 50'h1001}) begin errors++; $display("FAIL t5_fill1: got %b/%0d/%h exp 1/1/1001", fill_valid, fill_idx, fill_paddr); end
    checks++; if (fill_data !== d1) begin errors++; $display("FAIL t5_data1: got %h exp %h", fill_data, d1); end
    tick();
    resp_valid = 1'b0;
    settle();
    checks++; if ({fill_valid, entry_busy} !== 5'b0_0000) begin errors++; $display("FAIL t5_stray: got %b exp 00000", {fill_valid, entry_busy}); end
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0] d;
    d = {16{32'h1234_5678}};
    do_reset();
    set_req(0, 56'h3000); set_req(1, 56'h3040);
    tick();
    req_valid = '0;
    ext_req_ready = 1'b1;
    tick();
    resp_valid = 1'b1; resp_tag = 2'd0; resp_data = d;
    settle();
    checks++; if ({ext_req_valid, ext_req_tag, ext_req_paddr} !== {1'b1, 2'd1, 50'hC1}) begin errors++; $display("FAIL t7_ext1: got %b/%0d/%h exp 1/1/c1", ext_req_valid, ext_req_tag, ext_req_paddr); end
    tick();
    ext_req_ready = 1'b0; resp_valid = 1'b0;
    set_req(0, 56'h3000);
    settle();
    checks++; if ({fill_valid, fill_idx, fill_paddr} !== {1'b1, 2'd0, 50'hC0}) begin errors++; $display("FAIL t7_fill: got %b/%0d/%h exp 1/0/c0", fill_valid, fill_idx, fill_paddr); end
    checks++; if ({ext_req_valid, entry_busy} !== 5'b0_0011) begin errors++; $display("FAIL t7_states: got %b exp 00011", {ext_req_valid, entry_busy}); end
    checks++; if ({req_full[0], req_merged[0], req_idx[1:0]} !== 4'b0010) begin errors++; $display("FAIL t7_fill_nomatch: got %b exp 0010", {req_full[0], req_merged[0], req_idx[1:0]}); end
    tick();
    req_valid = '0;
    settle();
    checks++; if (entry_busy !== 4'b0110) begin errors++; $display("FAIL t7_busy_after: got %b exp 0110", entry_busy); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    set_req(0, 56'h5000); set_req(1, 56'h5040);
    tick();
    req_valid = '0;
    ext_req_ready = 1'b1;
    tick(); tick();
    ext_req_ready = 1'b0;
    settle();
    checks++; if ({ext_req_valid, entry_busy} !== 5'b0_0011) begin errors++; $display("FAIL t6_pre: got %b exp 00011", {ext_req_valid, entry_busy}); end
    reset = 1'b1;
    tick();
    settle();
    checks++; if ({entry_busy, ext_req_valid, fill_valid, req_full, req_merged} !== 10'b0) begin errors++; $display("FAIL t6_reset_out: got %b exp 0", {entry_busy, ext_req_valid, fill_valid, req_full, req_merged}); end
    reset = 1'b0;
    resp_valid = 1'b1; resp_tag = 2'd0; resp_data = {16{32'hFFFF_0000}};
    tick();
    resp_valid = 1'b0;
    settle();
    checks++; if ({fill_valid, entry_busy} !== 5'b0) begin errors++; $display("FAIL t6_stale_resp: got %b exp 00000", {fill_valid, entry_busy}); end
    checks++; if (fill_data !== 512'h0) begin errors++; $display("FAIL t6_fill_data: got %h exp 0", fill_data); end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_miss();
    test_same_cycle_merge();
    test_full_merge();
    test_rr_hold();
    test_ooo_resp();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
